stage_store_format: RTL and testbench

//   Store-side counterpart of the load/write-back path. Takes store requests
//   (byte address, register data, access size) from the memory-access stage
//   and drives word-aligned write beats to data memory. It shifts the data

---
 rtl/stage_store_format.sv | 174 +++++++++++++++++
 tb/tb_stage_store_format.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_store_format.sv
// Store formatter: turns (addr, data, size) store requests into word-aligned,
// lane-shifted, byte-masked dmem write beats, splitting word-crossing stores.

module store_lane #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 8,
    parameter int LANE      = 0
) (
    input  logic [$clog2(NUM_LANES)-1:0]     off,
    input  logic [NUM_LANES-1:0]             base,
    input  logic [NUM_LANES-1:0][VEC_W-1:0]  data,
    output logic [VEC_W-1:0]                 lane_byte,
    output logic                             lane_en
);
    localparam int IW = $clog2(NUM_LANES);

    int src;

    // Lane LANE of the two-word window receives source byte (LANE - off).
    // Data bytes land regardless of the size mask; only the enable is sized.
    always_comb begin
        src       = LANE - int'(off);
        lane_byte = '0;
        lane_en   = 1'b0;
        if (src >= 0 && src < NUM_LANES) begin
            lane_byte = data[src[IW-1:0]];
            lane_en   = base[src[IW-1:0]];
        end
    end
endmodule

module stage_store_format #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_pc_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    input  logic [2:0]  req_size_i,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_write_data_o,
    output logic [3:0]  dmem_write_mask_o,
    output logic        dmem_write_valid_o,
    input  logic        dmem_write_ready_i,
    output logic        done_o,
    output logic        misaligned_o,
    output logic        empty_async_o
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int IW        = $clog2(NUM_LANES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic [31:0]          data;
        logic [NUM_LANES-1:0] mask;
    } beat_t;

    state_t state;
    beat_t  beat_q, beat1_q;
    beat_t  beat0_c, beat1_c;
    logic   split_q, valid_q, done_q, mis_q;

    logic [NUM_LANES-1:0]                 base;
    logic [2*NUM_LANES-1:0][VEC_W-1:0]    win_data;
    logic [2*NUM_LANES-1:0]               win_mask;
    logic                                 split, accept;
    logic [31:0]                          addr0;

    // pc is carried for logging only; the formatter itself never looks at it
    logic unused_bits;
    assign unused_bits = ^{req_pc_i, req_size_i[2]};

    // size[2] is the unsigned flag (BU/HU); a store ignores it
    always_comb begin
        case (req_size_i[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
    end

    for (genvar l = 0; l < 2*NUM_LANES; l++) begin : g_lane
        store_lane #(
            .NUM_LANES (NUM_LANES),
            .VEC_W     (VEC_W),
            .LANE      (l)
        ) u_lane (
            .off       (req_addr_i[IW-1:0]),
            .base      (base),
            .data      (req_data_i),
            .lane_byte (win_data[l]),
            .lane_en   (win_mask[l])
        );
    end

    assign split  = |win_mask[2*NUM_LANES-1:NUM_LANES];
    assign addr0  = {req_addr_i[31:IW], {IW{1'b0}}};
    assign accept = req_valid_i & req_ready_o;

    always_comb begin
        beat0_c.addr = addr0;
        beat0_c.data = win_data[NUM_LANES-1:0];
        beat0_c.mask = win_mask[NUM_LANES-1:0];
        beat1_c.addr = addr0 + 32'd4;
        beat1_c.data = win_data[2*NUM_LANES-1:NUM_LANES];
        beat1_c.mask = win_mask[2*NUM_LANES-1:NUM_LANES];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= IDLE;
            beat_q  <= '0;
            beat1_q <= '0;
            split_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (split && !SPLIT_MISALIGNED) begin
                            mis_q <= 1'b1;
                        end else begin
                            beat_q  <= beat0_c;
                            beat1_q <= beat1_c;
                            split_q <= split;
                            valid_q <= 1'b1;
                            state   <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (dmem_write_ready_i) begin
                        if (split_q) begin
                            // second beat follows back-to-back, valid stays high
                            beat_q <= beat1_q;
                            state  <= BEAT1;
                        end else begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                BEAT1: begin
                    if (dmem_write_ready_i) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o        = (state == IDLE);
    assign empty_async_o      = (state == IDLE);
    assign dmem_addr_o        = beat_q.addr;
    assign dmem_write_data_o  = beat_q.data;
    assign dmem_write_mask_o  = beat_q.mask;
    assign dmem_write_valid_o = valid_q;
    assign done_o             = done_q;
    assign misaligned_o       = mis_q;
endmodule

// File: tb/tb_stage_store_format.sv
// Directed + randomized bench for stage_store_format, checked against an
// arithmetic model of the lane/mask/split rules.

module tb_stage_store_format;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        req_valid = 1'b0, req_valid_ns = 1'b0;
    logic [31:0] req_pc = 32'h0, req_addr = 32'h0, req_data = 32'h0;
    logic [2:0]  req_size = SW;
    logic        dmem_ready = 1'b0;
    logic        dmem_ready_ns = 1'b1;

    logic        req_ready, valid, done, mis, empty;
    logic [31:0] daddr, ddata;
    logic [3:0]  dmask;
    logic        req_ready_ns, valid_ns, done_ns, mis_ns, empty_ns;
    logic [31:0] daddr_ns, ddata_ns;
    logic [3:0]  dmask_ns;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stage_store_format #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_pc_i(req_pc), .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
        .dmem_addr_o(daddr), .dmem_write_data_o(ddata), .dmem_write_mask_o(dmask),
        .dmem_write_valid_o(valid), .dmem_write_ready_i(dmem_ready),
        .done_o(done), .misaligned_o(mis), .empty_async_o(empty)
    );

    stage_store_format #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid_ns), .req_ready_o(req_ready_ns),
        .req_pc_i(req_pc), .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
        .dmem_addr_o(daddr_ns), .dmem_write_data_o(ddata_ns), .dmem_write_mask_o(dmask_ns),
        .dmem_write_valid_o(valid_ns), .dmem_write_ready_i(dmem_ready_ns),
        .done_o(done_ns), .misaligned_o(mis_ns), .empty_async_o(empty_ns)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: byte count from size, mask shifted by offset, data widened to 64 bits and shifted.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                         output logic [31:0] a0, output logic [31:0] a1,
                         output logic [31:0] d0, output logic [31:0] d1,
                         output logic [3:0] m0, output logic [3:0] m1, output bit sp);
        int nb;
        int off;
        logic [15:0] m16;
        logic [63:0] d64;
        nb  = (s == SB || s == BU) ? 1 : (s == SH || s == HU) ? 2 : 4;
        off = int'(a % 4);
        m16 = ((16'd1 << nb) - 16'd1) << off;
        d64 = {32'd0, d} << (8 * off);
        a0  = a - (a % 4);
        a1  = a0 + 32'd4;
        d0  = d64[31:0];
        d1  = d64[63:32];
        m0  = m16[3:0];
        m1  = m16[7:4];
        sp  = (m16[7:4] != 4'd0);
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m);
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_addr"}, 64'(daddr), 64'(a));
        check({tag, "_data"}, 64'(ddata), 64'(d));
        check({tag, "_mask"}, 64'(dmask), 64'(m));
        check({tag, "_nodone"}, 64'(done), 64'd0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] s, input int bp0, input int bp1);
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  m0, m1;
        bit          sp;
        model(a, d, s, a0, a1, d0, d1, m0, m1, sp);
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        req_pc    = $urandom;
        req_valid = 1'b1;
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        tick;
        req_valid = 1'b0;
        for (int b = 0; b < (sp ? 2 : 1); b++) begin
            for (int k = 0; k < (b == 0 ? bp0 : bp1); k++) begin
                dmem_ready = 1'b0;
                check_beat({tag, b == 0 ? "_b0hold" : "_b1hold"}, b == 0 ? a0 : a1,
                           b == 0 ? d0 : d1, b == 0 ? m0 : m1);
                check({tag, "_busy"}, 64'(req_ready), 64'd0);
                tick;
            end
            dmem_ready = 1'b1;
            check_beat({tag, b == 0 ? "_b0" : "_b1"}, b == 0 ? a0 : a1,
                       b == 0 ? d0 : d1, b == 0 ? m0 : m1);
            tick;
            dmem_ready = 1'b0;
        end
        check({tag, "_valid_drop"}, 64'(valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_mis"}, 64'(mis), 64'd0);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        tick;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [2:0] sizes [5];
        sizes = '{SB, SH, SW, BU, HU};

        // reset state
        tick;
        tick;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mis", 64'(mis), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_addr", 64'(daddr), 64'd0);
        check("rst_data", 64'(ddata), 64'd0);
        check("rst_mask", 64'(dmask), 64'd0);
        reset_ni = 1'b1;
        tick;

        do_store("sw_aligned", 32'h0000_0100, 32'hDEAD_BEEF, SW, 0, 0);
        do_store("sb_off3",    32'h0000_0203, 32'h0000_00AB, SB, 0, 0);
        do_store("sw_split",   32'h0000_0401, 32'h1122_3344, SW, 0, 0);
        do_store("sw_split_bp", 32'h0000_0401, 32'h1122_3344, SW, 3, 0);
        do_store("sh_wrap",    32'hFFFF_FFFF, 32'h0000_BEEF, SH, 1, 2);
        do_store("hu_off2",    32'h0000_0802, 32'hCAFE_F00D, HU, 0, 0);

        // non-splitting instance rejects a word-crossing store
        req_addr     = 32'hFFFF_FFFF;
        req_data     = 32'h0000_BEEF;
        req_size     = SH;
        req_valid_ns = 1'b1;
        check("ns_ready", 64'(req_ready_ns), 64'd1);
        tick;
        req_valid_ns = 1'b0;
        check("ns_mis", 64'(mis_ns), 64'd1);
        check("ns_novalid", 64'(valid_ns), 64'd0);
        check("ns_nodone", 64'(done_ns), 64'd0);
        check("ns_empty", 64'(empty_ns), 64'd1);
        tick;
        check("ns_mis_pulse", 64'(mis_ns), 64'd0);
        check("ns_nodone2", 64'(done_ns), 64'd0);
        check("ns_novalid2", 64'(valid_ns), 64'd0);

        // non-splitting instance still writes an aligned store
        req_addr     = 32'h0000_0100;
        req_data     = 32'h1234_5678;
        req_size     = SW;
        req_valid_ns = 1'b1;
        tick;
        req_valid_ns = 1'b0;
        check("ns_sw_valid", 64'(valid_ns), 64'd1);
        check("ns_sw_addr", 64'(daddr_ns), 64'h100);
        check("ns_sw_mask", 64'(dmask_ns), 64'hF);
        check("ns_sw_nomis", 64'(mis_ns), 64'd0);
        tick;
        check("ns_sw_drop", 64'(valid_ns), 64'd0);
        check("ns_sw_done", 64'(done_ns), 64'd1);
        tick;

        // reset during the second beat abandons the store
        req_addr  = 32'h0000_0401;
        req_data  = 32'h1122_3344;
        req_size  = SW;
        req_valid = 1'b1;
        tick;
        req_valid  = 1'b0;
        dmem_ready = 1'b1;
        tick;
        dmem_ready = 1'b0;
        check("rb1_valid", 64'(valid), 64'd1);
        check("rb1_addr", 64'(daddr), 64'h404);
        reset_ni = 1'b0;
        #1;
        check("rb1_async_drop", 64'(valid), 64'd0);
        check("rb1_ready", 64'(req_ready), 64'd1);
        check("rb1_empty", 64'(empty), 64'd1);
        tick;
        reset_ni = 1'b1;
        tick;
        check("rb1_nodone", 64'(done), 64'd0);
        check("rb1_still_idle", 64'(valid), 64'd0);
        do_store("post_reset", 32'h0000_0100, 32'hDEAD_BEEF, SW, 0, 0);

        for (int i = 0; i < 40; i++) begin
            do_store("rand", $urandom, $urandom, sizes[$urandom_range(0, 4)],
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
